// File: rtl/hsa_skew_feeder_if.sv
// Operand and control bundle between a tile source and the systolic skew feeder.
// N lanes of W bits each for the A and B operand vectors.
interface hsa_skew_feeder_if #(
   parameter int N = 4,
   parameter int W = 16
);
   logic           start;
   logic [7:0]     k_len;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] a_vec;
   logic [N*W-1:0] b_vec;
   logic [N*W-1:0] a_out;
   logic [N*W-1:0] b_out;
   logic           en_out;
   logic           busy;
   logic           done;

   modport master (
      output start, k_len, in_valid, a_vec, b_vec,
      input  in_ready, a_out, b_out, en_out, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, a_vec, b_vec,
      output in_ready, a_out, b_out, en_out, busy, done
   );
endinterface

// File: rtl/hsa_skew_feeder.sv
// Feeds K_LEN beats of A columns / B rows into an N x N systolic array with a
// per-lane diagonal skew, then flushes the array and pulses DONE.
module hsa_skew_feeder #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic              clk,
   input  logic              rst,
   hsa_skew_feeder_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   localparam int             FW        = $clog2(2 * N);
   localparam logic [FW-1:0]  FLUSH_LEN = FW'(2 * N - 1);
   localparam logic [FW-1:0]  FLUSH_ONE = {{(FW-1){1'b0}}, 1'b1};

   state_t         state_r, state_s;
   logic [7:0]     beat_cnt_r, beat_cnt_s;
   logic [FW-1:0]  flush_cnt_r, flush_cnt_s;
   logic           advance_s;
   logic [N*W-1:0] skew_a_s, skew_b_s;
   logic [N*W-1:0] a_out_s, b_out_s;

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         beat_cnt_r  <= 8'd0;
         flush_cnt_r <= {FW{1'b0}};
      end else begin
         state_r     <= state_s;
         beat_cnt_r  <= beat_cnt_s;
         flush_cnt_r <= flush_cnt_s;
      end
   end

   // Next-state and counter update logic
   always_comb begin
      state_s     = state_r;
      beat_cnt_s  = beat_cnt_r;
      flush_cnt_s = flush_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && (bus.k_len != 8'd0)) begin
               state_s    = ST_LOAD;
               beat_cnt_s = bus.k_len;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (bus.in_valid) begin
               if (beat_cnt_r == 8'd1) begin
                  state_s     = ST_FLUSH;
                  beat_cnt_s  = 8'd0;
                  flush_cnt_s = FLUSH_LEN;
               end else begin
                  beat_cnt_s  = beat_cnt_r - 8'd1;
               end
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_r == FLUSH_ONE) begin
               state_s     = ST_FIN;
               flush_cnt_s = {FW{1'b0}};
            end else begin
               flush_cnt_s = flush_cnt_r - FLUSH_ONE;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s     = ST_IDLE;
            beat_cnt_s  = 8'd0;
            flush_cnt_s = {FW{1'b0}};
         end
      endcase
   end

   // A stalled beat must not move the wavefront, so shifting follows the array enable.
   assign advance_s = ((state_r == ST_LOAD) && bus.in_valid) || (state_r == ST_FLUSH);
   assign skew_a_s  = (state_r == ST_LOAD) ? bus.a_vec : {(N*W){1'b0}};
   assign skew_b_s  = (state_r == ST_LOAD) ? bus.b_vec : {(N*W){1'b0}};

   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_pass
         assign a_out_s[W-1:0] = skew_a_s[W-1:0];
         assign b_out_s[W-1:0] = skew_b_s[W-1:0];
      end else begin : g_dly
         logic [W-1:0] a_pipe_r [i];
         logic [W-1:0] b_pipe_r [i];

         // Lane i delay line, i stages deep, clocked by array advances
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < i; k++) begin
                  a_pipe_r[k] <= {W{1'b0}};
                  b_pipe_r[k] <= {W{1'b0}};
               end
            end else if (advance_s) begin
               a_pipe_r[0] <= skew_a_s[i*W +: W];
               b_pipe_r[0] <= skew_b_s[i*W +: W];
               for (int k = 1; k < i; k++) begin
                  a_pipe_r[k] <= a_pipe_r[k-1];
                  b_pipe_r[k] <= b_pipe_r[k-1];
               end
            end
         end

         assign a_out_s[i*W +: W] = a_pipe_r[i-1];
         assign b_out_s[i*W +: W] = b_pipe_r[i-1];
      end
   end

   assign bus.a_out    = a_out_s;
   assign bus.b_out    = b_out_s;
   assign bus.en_out   = advance_s;
   assign bus.in_ready = (state_r == ST_LOAD);
   assign bus.busy     = (state_r == ST_LOAD) || (state_r == ST_FLUSH);
   assign bus.done     = (state_r == ST_FIN);

endmodule

// File: tb/tb_hsa_skew_feeder.sv
// Directed bench for hsa_skew_feeder (N=4, W=16) with a behavioural 4x4
// output-stationary PE array attached to the skewed outputs.
module tb_hsa_skew_feeder;

   localparam int N = 4;
   localparam int W = 16;

   logic clk;
   logic rst;
   logic c_clr;
   int   total;
   int   bad;

   hsa_skew_feeder_if #(.N(N), .W(W)) bus ();

   hsa_skew_feeder #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] a_beats [8];
   logic [63:0] b_beats [8];
   logic [63:0] a_snap  [64];
   logic [63:0] b_snap  [64];
   int          done_cyc;
   int          done_cnt;
   int          en_cnt;

   int pe_a [N][N];
   int pe_b [N][N];
   int c    [N][N];

   function automatic logic [15:0] lane(input logic [63:0] v, input int i);
      return v[i*16 +: 16];
   endfunction

   function automatic logic [63:0] pack(input int l0, input int l1, input int l2, input int l3);
      return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
   endfunction

   function automatic int a_in(input int i, input int j);
      if (j == 0) return int'(lane(bus.a_out, i));
      else        return pe_a[i][j-1];
   endfunction

   function automatic int b_in(input int i, input int j);
      if (i == 0) return int'(lane(bus.b_out, j));
      else        return pe_b[i-1][j];
   endfunction

   // Output-stationary PE grid: A flows east, B flows south, C accumulates
   always @(posedge clk) begin
      if (c_clr) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pe_a[i][j] <= 0;
               pe_b[i][j] <= 0;
               c[i][j]    <= 0;
            end
      end else if (bus.en_out) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pe_a[i][j] <= a_in(i, j);
               pe_b[i][j] <= b_in(i, j);
               c[i][j]    <= c[i][j] + a_in(i, j) * b_in(i, j);
            end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one tile; START in cycle 0, the first LOAD cycle is cycle 1.
   task automatic run_tile(input int klen, input int gap_at, input int gap_len,
                           input int start_at, input int exp_done, input bit chk_c);
      logic [63:0] ha [64];
      logic [63:0] hb [64];
      logic [63:0] sa, sb, ea, eb;
      int n_adv, acc, gl, fl;
      bit ld, flsh, fin, vld;
      n_adv = 0; acc = 0; gl = 0; fl = 0;
      done_cyc = -1; done_cnt = 0; en_cnt = 0;
      bus.start    = 1'b1;
      bus.k_len    = klen[7:0];
      bus.in_valid = 1'b0;
      c_clr        = 1'b1;
      #1;
      check("start_rdy", 64'(bus.in_ready), 64'd0);
      check("start_en", 64'(bus.en_out), 64'd0);
      @(posedge clk); #1;
      c_clr     = 1'b0;
      bus.start = 1'b0;
      for (int cyc = 1; cyc < 64; cyc++) begin
         ld   = (acc < klen);
         flsh = !ld && (fl > 0);
         fin  = !ld && (fl == 0);
         vld  = ld && (gl == 0);
         bus.start    = (cyc == start_at);
         bus.in_valid = vld;
         if (vld) begin
            bus.a_vec = a_beats[acc];
            bus.b_vec = b_beats[acc];
         end
         sa = ld ? bus.a_vec : 64'd0;
         sb = ld ? bus.b_vec : 64'd0;
         ea = 64'd0;
         eb = 64'd0;
         ea[15:0] = sa[15:0];
         eb[15:0] = sb[15:0];
         for (int i = 1; i < N; i++) begin
            if (n_adv - i >= 0) begin
               ea[i*16 +: 16] = lane(ha[n_adv-i], i);
               eb[i*16 +: 16] = lane(hb[n_adv-i], i);
            end
         end
         #1;
         a_snap[cyc] = bus.a_out;
         b_snap[cyc] = bus.b_out;
         check("in_ready", 64'(bus.in_ready), 64'(ld));
         check("en_out", 64'(bus.en_out), 64'((ld && vld) || flsh));
         check("busy", 64'(bus.busy), 64'(ld || flsh));
         check("done", 64'(bus.done), 64'(fin));
         check("a_out", bus.a_out, ea);
         check("b_out", bus.b_out, eb);
         if (bus.en_out) en_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if ((ld && vld) || flsh) begin
            ha[n_adv] = sa;
            hb[n_adv] = sb;
            n_adv++;
         end
         if (ld && vld) begin
            acc++;
            if (acc == gap_at) gl = gap_len;
            if (acc == klen)   fl = 2 * N - 1;
         end else if (ld) begin
            gl--;
         end
         if (flsh) fl--;
         @(posedge clk); #1;
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         if (fin) break;
      end
      check("done_cycle", 64'(done_cyc), 64'(exp_done));
      check("done_count", 64'(done_cnt), 64'd1);
      check("en_count", 64'(en_cnt), 64'(klen + 2 * N - 1));
      if (chk_c) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               check("c_elem", 64'(c[i][j]), (i == j) ? 64'd1 : 64'd0);
      end
   endtask

   task automatic load_identity;
      for (int k = 0; k < N; k++) begin
         a_beats[k] = 64'd1 << (k * 16);
         b_beats[k] = 64'd1 << (k * 16);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      c_clr = 1'b0;
      rst   = 1'b1;
      bus.start    = 1'b1;
      bus.k_len    = 8'd4;
      bus.in_valid = 1'b1;
      bus.a_vec    = pack(1, 2, 3, 4);
      bus.b_vec    = pack(5, 6, 7, 8);

      // reset state with active-looking inputs
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", 64'(bus.in_ready), 64'd0);
      check("rst_en", 64'(bus.en_out), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_a", bus.a_out, 64'd0);
      check("rst_b", bus.b_out, 64'd0);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      rst          = 1'b0;
      @(posedge clk); #1;

      // single beat, lane i shows i+1 exactly i cycles after acceptance; START in FIN
      a_beats[0] = pack(1, 2, 3, 4);
      b_beats[0] = pack(5, 6, 7, 8);
      run_tile(1, 0, 0, 9, 9, 1'b0);
      for (int i = 0; i < N; i++) begin
         check("skew_a", 64'(lane(a_snap[1+i], i)), 64'(i + 1));
         check("skew_b", 64'(lane(b_snap[1+i], i)), 64'(i + 5));
      end
      check("fin_start_rdy", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      check("fin_start_busy", 64'(bus.busy), 64'd0);

      // identity tile, then back-to-back identity tile
      load_identity();
      run_tile(4, 0, 0, 0, 12, 1'b1);
      run_tile(4, 0, 0, 0, 12, 1'b1);

      // three-cycle bubble between beats 2 and 3
      run_tile(4, 2, 3, 0, 15, 1'b1);

      // START during FLUSH
      run_tile(4, 0, 0, 7, 12, 1'b1);

      // START with K_LEN=0 is ignored
      bus.start = 1'b1;
      bus.k_len = 8'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("k0_rdy", 64'(bus.in_ready), 64'd0);
         check("k0_done", 64'(bus.done), 64'd0);
         @(posedge clk); #1;
      end

      // asynchronous reset mid-LOAD after beat 2 of 4
      bus.start    = 1'b1;
      bus.k_len    = 8'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1;
         bus.a_vec    = pack(k + 1, 1, 1, 1);
         bus.b_vec    = pack(2, k + 2, 2, 2);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.a_vec    = pack(9, 10, 11, 12);
      bus.b_vec    = pack(13, 14, 15, 16);
      check("mid_busy", 64'(bus.busy), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      check("arst_rdy", 64'(bus.in_ready), 64'd0);
      check("arst_en", 64'(bus.en_out), 64'd0);
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_a", bus.a_out, 64'd0);
      check("arst_b", bus.b_out, 64'd0);
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("post_rst_done", 64'(bus.done), 64'd0);
      @(posedge clk); #1;

      // fresh two-beat tile after reset
      a_beats[0] = pack(9, 10, 11, 12);
      b_beats[0] = pack(13, 14, 15, 16);
      a_beats[1] = pack(17, 18, 19, 20);
      b_beats[1] = pack(21, 22, 23, 24);
      run_tile(2, 0, 0, 0, 10, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
